// File: rtl/corelet_pkg.sv
// Shared constants and helpers for the corelet datapath blocks.
package corelet_pkg;

    localparam int unsigned COL         = 8;
    localparam int unsigned PSUM_BW     = 16;
    localparam int unsigned OFIFO_DEPTH = 64;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) result = result + 1;
        return result;
    endfunction

endpackage

// File: rtl/ofifo_col.sv
// One first-word-fall-through FIFO lane; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module ofifo_col
    import corelet_pkg::*;
#(
    parameter int unsigned bw    = PSUM_BW,
    parameter int unsigned depth = OFIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] in,
    output logic [bw-1:0] out,
    output logic          o_empty,
    output logic          o_full
);

    localparam int unsigned AW = clog2(depth);

    logic [bw-1:0] mem [depth];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          push;
    logic          pop;

    assign o_empty = (wptr == rptr);
    assign o_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign push    = wr && !o_full;
    assign pop     = rd && !o_empty;
    assign out     = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wptr[AW-1:0]] <= in;
    end

endmodule

// File: rtl/ofifo.sv
// Output FIFO array: deskews per-column psum pushes and presents one complete
// col-wide vector, popped atomically across all lanes.
module ofifo
    import corelet_pkg::*;
#(
    parameter int unsigned col   = COL,
    parameter int unsigned bw    = PSUM_BW,
    parameter int unsigned depth = OFIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_ovf
);

    logic [col-1:0]    empty;
    logic [col-1:0]    full;
    logic [col*bw-1:0] head;
    logic              pop;

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = !o_full;
    // Pops only when every lane has data, so lanes never drift apart.
    assign pop     = rd && o_valid;
    assign out     = o_valid ? head : '0;

    for (genvar i = 0; i < col; i++) begin : g_col
        ofifo_col #(
            .bw   (bw),
            .depth(depth)
        ) u_col (
            .clk    (clk),
            .reset  (reset),
            .wr     (wr[i]),
            .rd     (pop),
            .in     (in[bw*i +: bw]),
            .out    (head[bw*i +: bw]),
            .o_empty(empty[i]),
            .o_full (full[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_ovf <= 1'b0;
        end else if (|(wr & full)) begin
            o_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo against a queue-per-column reference model.
module tb_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int VW    = COL * BW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] in = '0;
    logic [COL-1:0] wr = '0;
    logic          rd = 1'b0;
    logic [VW-1:0] out;
    logic          o_valid, o_full, o_ready, o_ovf;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] mq [COL][$];
    logic          m_ovf = 1'b0;

    always #5 clk = ~clk;

    ofifo #(.col(COL), .bw(BW), .depth(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .wr     (wr),
        .rd     (rd),
        .out    (out),
        .o_valid(o_valid),
        .o_full (o_full),
        .o_ready(o_ready),
        .o_ovf  (o_ovf)
    );

    function automatic logic m_valid();
        for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < COL; i++) if (mq[i].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [VW-1:0] m_out();
        logic [VW-1:0] r;
        r = '0;
        if (m_valid()) for (int i = 0; i < COL; i++) r[i*BW +: BW] = mq[i][0];
        return r;
    endfunction

    function automatic logic [VW+3:0] m_tuple();
        return {m_valid(), m_full(), !m_full(), m_ovf, m_out()};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Drive one cycle, advance the model with pre-edge state, sample 1ns after the edge.
    task automatic step(input logic r, input logic [COL-1:0] w,
                        input logic [VW-1:0] d, input logic p);
        logic v;
        reset = r; wr = w; in = d; rd = p;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < COL; i++) mq[i].delete();
            m_ovf = 1'b0;
        end else begin
            v = m_valid();
            for (int i = 0; i < COL; i++) begin
                if (w[i]) begin
                    if (mq[i].size() == DEPTH) m_ovf = 1'b1;
                    else mq[i].push_back(d[i*BW +: BW]);
                end
            end
            if (p && v) for (int i = 0; i < COL; i++) void'(mq[i].pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, '1, rand_vec(), 1'b1);
            checks++;
            if ({o_valid, o_full, o_ready, o_ovf, out} !== {4'b0010, {VW{1'b0}}}) begin
                errors++;
                $display("FAIL reset cyc%0d: got v=%b f=%b r=%b ovf=%b out=%h, want 0010 out=0",
                         c, o_valid, o_full, o_ready, o_ovf, out);
            end
        end
        step(1'b0, '0, '0, 1'b0);
        checks++;
        if ({o_valid, o_full, o_ready, o_ovf, out} !== {4'b0010, {VW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_release: got v=%b f=%b r=%b ovf=%b out=%h", o_valid, o_full, o_ready, o_ovf, out);
        end
    endtask

    task automatic test_skewed_fill();
        logic [VW-1:0] d, want;
        want = '0;
        for (int i = 0; i < COL; i++) begin
            d = rand_vec();
            d[i*BW +: BW] = 16'h0100 + 16'(i);
            want[i*BW +: BW] = 16'h0100 + 16'(i);
            step(1'b0, COL'(1) << i, d, 1'b0);
            checks++;
            if (o_valid !== (i == COL - 1)) begin
                errors++;
                $display("FAIL skew_valid cyc%0d: got %b want %b", i, o_valid, (i == COL - 1));
            end
        end
        checks++;
        if (out !== want) begin
            errors++;
            $display("FAIL skew_out: got %h want %h", out, want);
        end
        step(1'b0, '0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL skew_pop: got v=%b out=%h want v=0 out=0", o_valid, out);
        end
    endtask

    task automatic test_streaming();
        localparam int NV = 200;
        logic [COL-1:0] w;
        logic [VW-1:0] d, want;
        int k;
        int exp_k = 0;
        for (int t = 0; t < NV + COL + 2; t++) begin
            w = '0; d = '0;
            for (int i = 0; i < COL; i++) begin
                k = t - i;
                if (k >= 0 && k < NV) begin
                    w[i] = 1'b1;
                    d[i*BW +: BW] = BW'(k * COL + i);
                end
            end
            step(1'b0, w, d, 1'b1);
            if (o_valid === 1'b1) begin
                for (int i = 0; i < COL; i++) want[i*BW +: BW] = BW'(exp_k * COL + i);
                checks++;
                if (out !== want) begin
                    errors++;
                    $display("FAIL stream_vec%0d: got %h want %h", exp_k, out, want);
                end
                exp_k++;
            end
        end
        checks++;
        if (exp_k != NV || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: got %0d vectors v=%b, want %0d v=0", exp_k, o_valid, NV);
        end
    endtask

    task automatic test_full();
        step(1'b1, '0, '0, 1'b0);
        for (int v = 0; v < DEPTH; v++) step(1'b0, '1, rand_vec(), 1'b0);
        checks++;
        if ({o_valid, o_full, o_ready, o_ovf} !== 4'b1100) begin
            errors++;
            $display("FAIL full_flags: got v=%b f=%b r=%b ovf=%b want 1100", o_valid, o_full, o_ready, o_ovf);
        end
        step(1'b0, 8'h08, rand_vec(), 1'b0);
        checks++;
        if (o_ovf !== 1'b1 || {o_valid, o_full, o_ready, o_ovf, out} !== m_tuple()) begin
            errors++;
            $display("FAIL full_ovf: got ovf=%b out=%h want ovf=1 out=%h", o_ovf, out, m_out());
        end
        // First pop also retries lane 3 while it is still full: the push must drop.
        for (int j = 0; j < DEPTH; j++) begin
            step(1'b0, (j == 0) ? 8'h08 : 8'h00, rand_vec(), 1'b1);
            checks++;
            if ({o_valid, o_full, o_ready, o_ovf, out} !== m_tuple()) begin
                errors++;
                $display("FAIL full_drain%0d: got v=%b f=%b ovf=%b out=%h want %h",
                         j, o_valid, o_full, o_ovf, out, m_tuple());
            end
        end
        checks++;
        if (o_valid !== 1'b0 || o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL full_empty_end: got v=%b ovf=%b want v=0 ovf=1", o_valid, o_ovf);
        end
    endtask

    task automatic test_empty_pop();
        step(1'b1, '0, '0, 1'b0);
        step(1'b0, 8'h7F, rand_vec(), 1'b0);
        step(1'b0, '0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b0 || o_ovf !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL empty_pop: got v=%b ovf=%b out=%h want v=0 ovf=0 out=0", o_valid, o_ovf, out);
        end
        step(1'b0, 8'h80, rand_vec(), 1'b0);
        checks++;
        if (o_valid !== 1'b1 || out !== m_out()) begin
            errors++;
            $display("FAIL empty_fill7: got v=%b out=%h want v=1 out=%h", o_valid, out, m_out());
        end
    endtask

    task automatic test_simultaneous();
        logic [VW-1:0] d;
        step(1'b1, '0, '0, 1'b0);
        for (int v = 0; v < DEPTH - 1; v++) step(1'b0, '1, rand_vec(), 1'b0);
        step(1'b0, '1, rand_vec(), 1'b1);
        checks++;
        if (o_full !== 1'b0 || {o_valid, o_full, o_ready, o_ovf, out} !== m_tuple()) begin
            errors++;
            $display("FAIL simul_pushpop: got f=%b out=%h want f=0 out=%h", o_full, out, m_out());
        end
        step(1'b0, '1, rand_vec(), 1'b0);
        checks++;
        if (o_full !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_depth: got f=%b r=%b want f=1 r=0", o_full, o_ready);
        end
        step(1'b1, '1, rand_vec(), 1'b1);
        checks++;
        if ({o_valid, o_full, o_ready, o_ovf, out} !== {4'b0010, {VW{1'b0}}}) begin
            errors++;
            $display("FAIL midreset: got v=%b f=%b r=%b ovf=%b out=%h", o_valid, o_full, o_ready, o_ovf, out);
        end
        step(1'b0, '0, '0, 1'b1);
        checks++;
        if (o_valid !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL midreset_after: got v=%b out=%h want v=0 out=0", o_valid, out);
        end
        d = rand_vec();
        step(1'b0, '1, d, 1'b0);
        checks++;
        if (o_valid !== 1'b1 || out !== d) begin
            errors++;
            $display("FAIL midreset_newdata: got v=%b out=%h want v=1 out=%h", o_valid, out, d);
        end
    endtask

    task automatic test_random();
        logic [COL-1:0] w;
        logic p;
        step(1'b1, '0, '0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            w = COL'($urandom);
            if (c % 8 == 0) w = '1;
            // Alternate write-heavy and read-heavy phases so both full and empty are visited.
            p = ((c / 150) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            step((c == 450), w, rand_vec(), p);
            checks++;
            if ({o_valid, o_full, o_ready, o_ovf, out} !== m_tuple()) begin
                errors++;
                $display("FAIL random cyc%0d: got v=%b f=%b r=%b ovf=%b out=%h want %h",
                         c, o_valid, o_full, o_ready, o_ovf, out, m_tuple());
            end
        end
    endtask

    initial begin
        test_reset();
        test_skewed_fill();
        test_streaming();
        test_full();
        test_empty_pop();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
